// File: rtl/networkadapter_pkg.sv
// -----------------------------------------------------------------------------
// networkadapter_pkg
//   Shared definitions for the network adapter AHB front-end.
//   - Target index constants. Each target owns one 16 KiB region.
//   - Region decode position.
//   - State type for the AHB demux FSM.
//   - Helper that turns a target index into a one-hot select.
// -----------------------------------------------------------------------------
package networkadapter_pkg;

  localparam int NA_TGT_CONF     = 0;
  localparam int NA_TGT_MPSIMPLE = 1;
  localparam int NA_TGT_DMA      = 2;
  localparam int NA_NUM_TGT      = 3;

  // haddr[NA_REGION_LSB +: 2] picks the 16 KiB target region
  localparam int NA_REGION_LSB   = 14;

  typedef enum logic [1:0] {
    NA_ST_IDLE = 2'd0,
    NA_ST_DATA = 2'd1,
    NA_ST_ERR1 = 2'd2,
    NA_ST_ERR2 = 2'd3
  } na_demux_state_t;

  // One-hot target select for a 2-bit region index. Index 3 yields all zeros.
  function automatic logic [NA_NUM_TGT-1:0] na_tgt_onehot(input logic [1:0] idx);
    logic [NA_NUM_TGT-1:0] oh;
    oh = '0;
    for (int i = 0; i < NA_NUM_TGT; i++) begin
      if (idx == 2'(i)) begin
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/networkadapter_ahb_demux.sv
// -----------------------------------------------------------------------------
// networkadapter_ahb_demux
//   AHB-Lite slave front-end of the network adapter. It captures the address
//   phase and decodes it into one of three 16 KiB target regions: conf,
//   mpsimple and dma. It then presents a registered request, aligned to the
//   data phase, to the selected target. Target responses are merged back
//   upstream. Target errors, unmapped accesses and stalled targets all become
//   a two-cycle AHB ERROR.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   hsel, haddr, hwrite, hsize, htrans, hready
//                  upstream address phase (hready is the bus-wide hreadyin)
//   hwdata         upstream write data (data phase)
//   hrdata, hreadyout, hresp
//                  upstream data-phase response
//   t_hsel         one-hot target select, asserted only in the data phase
//   t_haddr, t_hwrite, t_hsize
//                  registered request fields; t_haddr is the in-region offset
//   t_hwdata       pass-through of hwdata
//   t_hrdata, t_hready, t_hresp
//                  per-target response; target i read data is at [i*XLEN +: XLEN]
// -----------------------------------------------------------------------------
module networkadapter_ahb_demux
  import networkadapter_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter logic [2:0] TARGET_EN = 3'b111,
  parameter int         TIMEOUT   = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hsel,
  input  logic [31:0]                haddr,
  input  logic [XLEN-1:0]            hwdata,
  input  logic                       hwrite,
  input  logic [2:0]                 hsize,
  input  logic [1:0]                 htrans,
  input  logic                       hready,
  output logic [XLEN-1:0]            hrdata,
  output logic                       hreadyout,
  output logic                       hresp,
  output logic [NA_NUM_TGT-1:0]      t_hsel,
  output logic [15:0]                t_haddr,
  output logic                       t_hwrite,
  output logic [2:0]                 t_hsize,
  output logic [XLEN-1:0]            t_hwdata,
  input  logic [NA_NUM_TGT*XLEN-1:0] t_hrdata,
  input  logic [NA_NUM_TGT-1:0]      t_hready,
  input  logic [NA_NUM_TGT-1:0]      t_hresp
);

  // The watchdog threshold is held in the same 8-bit domain as the wait counter
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  na_demux_state_t state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     t_haddr_q, t_haddr_d;
  logic            t_hwrite_q, t_hwrite_d;
  logic [2:0]      t_hsize_q, t_hsize_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;

  // ---------------------------------------------------------------------------
  // Address-phase decode
  // ---------------------------------------------------------------------------
  logic       accept;
  logic       mapped;
  logic [1:0] addr_idx;
  logic [3:0] tgt_en_ext;

  assign accept     = hsel & htrans[1] & hready;
  assign addr_idx   = haddr[NA_REGION_LSB +: 2];
  // Region index 3 has no target. The padded enable bit makes it unmapped.
  assign tgt_en_ext = {1'b0, TARGET_EN};
  assign mapped     = (haddr[31:16] == 16'h0000) && tgt_en_ext[addr_idx];

  // ---------------------------------------------------------------------------
  // Response of the target owning the current data phase
  // ---------------------------------------------------------------------------
  logic            sel_ready;
  logic            sel_resp;
  logic [XLEN-1:0] sel_rdata;

  always_comb begin
    sel_ready = 1'b0;
    sel_resp  = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NA_NUM_TGT; i++) begin
      if (idx_q == 2'(i)) begin
        sel_ready = t_hready[i];
        sel_resp  = t_hresp[i];
        sel_rdata = t_hrdata[i*XLEN +: XLEN];
      end
    end
  end

  logic [7:0] wait_cnt_inc;
  assign wait_cnt_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

  // ---------------------------------------------------------------------------
  // FSM: next state and upstream response
  // ---------------------------------------------------------------------------
  logic take_addr;   // this cycle ends any data phase, so a new accept may start

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    t_haddr_d  = t_haddr_q;
    t_hwrite_d = t_hwrite_q;
    t_hsize_d  = t_hsize_q;
    wait_cnt_d = wait_cnt_q;
    hreadyout  = 1'b1;
    hresp      = 1'b0;
    hrdata     = '0;
    take_addr  = 1'b0;

    case (state_q)
      NA_ST_IDLE: begin
        take_addr = 1'b1;
      end
      NA_ST_DATA: begin
        if (sel_resp) begin
          // Target error wins over ready. This cycle is a wait, and ERR1 follows.
          hreadyout = 1'b0;
          state_d   = NA_ST_ERR1;
        end else if (sel_ready) begin
          if (!t_hwrite_q) begin
            hrdata = sel_rdata;
          end
          take_addr = 1'b1;
        end else begin
          hreadyout  = 1'b0;
          wait_cnt_d = wait_cnt_inc;
          if ((TIMEOUT_C != 8'd0) && (wait_cnt_inc >= TIMEOUT_C)) begin
            state_d = NA_ST_ERR1;
          end
        end
      end
      NA_ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = NA_ST_ERR2;
      end
      NA_ST_ERR2: begin
        hresp     = 1'b1;
        take_addr = 1'b1;
      end
      default: begin
        state_d = NA_ST_IDLE;
      end
    endcase

    if (take_addr) begin
      state_d = NA_ST_IDLE;
      if (accept) begin
        if (mapped) begin
          state_d    = NA_ST_DATA;
          idx_d      = addr_idx;
          t_haddr_d  = {2'b00, haddr[NA_REGION_LSB-1:0]};
          t_hwrite_d = hwrite;
          t_hsize_d  = hsize;
          wait_cnt_d = 8'd0;
        end else begin
          state_d = NA_ST_ERR1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= NA_ST_IDLE;
      idx_q      <= 2'd0;
      t_haddr_q  <= 16'h0000;
      t_hwrite_q <= 1'b0;
      t_hsize_q  <= 3'd0;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      t_haddr_q  <= t_haddr_d;
      t_hwrite_q <= t_hwrite_d;
      t_hsize_q  <= t_hsize_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Target-side request
  // ---------------------------------------------------------------------------
  assign t_hsel   = (state_q == NA_ST_DATA) ? na_tgt_onehot(idx_q) : '0;
  assign t_haddr  = t_haddr_q;
  assign t_hwrite = t_hwrite_q;
  assign t_hsize  = t_hsize_q;
  assign t_hwdata = hwdata;

endmodule

// File: tb/tb_networkadapter_ahb_demux.sv
`timescale 1ns/1ps
module tb_networkadapter_ahb_demux;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              rst2;
  logic              hsel;
  logic [31:0]       haddr;
  logic [XLEN-1:0]   hwdata;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [1:0]        htrans;
  logic              hready, hready2;
  logic [XLEN-1:0]   hrdata, hrdata2;
  logic              hreadyout, hreadyout2;
  logic              hresp, hresp2;
  logic [2:0]        t_hsel, t_hsel2;
  logic [15:0]       t_haddr, t_haddr2;
  logic              t_hwrite, t_hwrite2;
  logic [2:0]        t_hsize, t_hsize2;
  logic [XLEN-1:0]   t_hwdata, t_hwdata2;
  logic [3*XLEN-1:0] t_hrdata;
  logic [2:0]        t_hready;
  logic [2:0]        t_hresp;

  // Single-slave bus: hreadyin follows the slave's own hreadyout
  assign hready  = hreadyout;
  assign hready2 = hreadyout2;

  always #5 clk = ~clk;

  // Main DUT: short watchdog, all targets present
  networkadapter_ahb_demux #(.XLEN(XLEN), .TARGET_EN(3'b111), .TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .hwdata(hwdata),
    .hwrite(hwrite), .hsize(hsize), .htrans(htrans), .hready(hready),
    .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp),
    .t_hsel(t_hsel), .t_haddr(t_haddr), .t_hwrite(t_hwrite), .t_hsize(t_hsize),
    .t_hwdata(t_hwdata), .t_hrdata(t_hrdata), .t_hready(t_hready), .t_hresp(t_hresp)
  );

  // Second DUT: watchdog disabled, dma target absent
  networkadapter_ahb_demux #(.XLEN(XLEN), .TARGET_EN(3'b011), .TIMEOUT(0)) u_dut2 (
    .clk(clk), .rst(rst2), .hsel(hsel), .haddr(haddr), .hwdata(hwdata),
    .hwrite(hwrite), .hsize(hsize), .htrans(htrans), .hready(hready2),
    .hrdata(hrdata2), .hreadyout(hreadyout2), .hresp(hresp2),
    .t_hsel(t_hsel2), .t_haddr(t_haddr2), .t_hwrite(t_hwrite2), .t_hsize(t_hsize2),
    .t_hwdata(t_hwdata2), .t_hrdata(t_hrdata), .t_hready(t_hready), .t_hresp(t_hresp)
  );

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        resp;
    int          waits;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_ph(input logic [31:0] a, input logic w);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = w;
    hsize  = 3'b010;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    haddr  = 32'h0;
    hwrite = 1'b0;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] rd, input logic resp, input int waits);
    exp_q.push_back('{tag: tag, rdata: rd, resp: resp, waits: waits});
  endtask

  // Wait (bounded) for the data phase to complete and compare it with the
  // oldest expected response. Returns just after the completing clock edge.
  task automatic collect();
    exp_t e;
    int   waits;
    bit   done;
    check("sb_not_empty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    e     = exp_q.pop_front();
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (hreadyout) begin
        done = 1'b1;
      end else begin
        waits++;
        tick();
      end
    end
    check({e.tag, "_done"}, 32'(done), 32'd1);
    check({e.tag, "_hrdata"}, hrdata, e.rdata);
    check({e.tag, "_hresp"}, 32'(hresp), 32'(e.resp));
    check({e.tag, "_waits"}, 32'(waits), 32'(e.waits));
    $display("xfer %s: hrdata=%h hresp=%0d waits=%0d", e.tag, hrdata, hresp, waits);
    tick();
  endtask

  initial begin
    int low;
    rst      = 1'b1;
    rst2     = 1'b1;
    bus_idle();
    hsize    = 3'b000;
    hwdata   = '0;
    t_hready = 3'b111;
    t_hresp  = 3'b000;
    t_hrdata = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010};
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_hresp",     32'(hresp),     32'd0);
    check("rst_hrdata",    hrdata,         32'd0);
    check("rst_t_hsel",    32'(t_hsel),    32'd0);
    check("rst_t_haddr",   32'(t_haddr),   32'd0);
    check("rst_t_hwrite",  32'(t_hwrite),  32'd0);
    check("rst_t_hsize",   32'(t_hsize),   32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Simple read from conf
    addr_ph(32'h0000_0004, 1'b0);
    push_exp("rd_conf", 32'h10, 1'b0, 0);
    tick();
    bus_idle();
    #1;
    check("rd_conf_t_hsel",   32'(t_hsel),   32'h1);
    check("rd_conf_t_haddr",  32'(t_haddr),  32'h0004);
    check("rd_conf_t_hsize",  32'(t_hsize),  32'h2);
    collect();

    // Back-to-back write to mpsimple then read from dma
    addr_ph(32'h0000_4000, 1'b1);
    push_exp("wr_mps", 32'h0, 1'b0, 0);
    tick();
    addr_ph(32'h0000_8008, 1'b0);
    hwdata = 32'hCAFE_0001;
    push_exp("rd_dma", 32'h30, 1'b0, 0);
    #1;
    check("wr_mps_t_hsel",   32'(t_hsel),   32'h2);
    check("wr_mps_t_hwrite", 32'(t_hwrite), 32'h1);
    check("wr_mps_t_haddr",  32'(t_haddr),  32'h0000);
    check("wr_mps_t_hwdata", t_hwdata,      32'hCAFE_0001);
    collect();
    bus_idle();
    #1;
    check("rd_dma_t_hsel",   32'(t_hsel),   32'h4);
    check("rd_dma_t_haddr",  32'(t_haddr),  32'h0008);
    check("rd_dma_t_hwrite", 32'(t_hwrite), 32'h0);
    collect();

    // Unmapped: region 3, then an address with upper bits set
    addr_ph(32'h0000_C000, 1'b0);
    push_exp("unm_c000", 32'h0, 1'b1, 1);
    tick();
    bus_idle();
    #1;
    check("unm_c000_t_hsel", 32'(t_hsel), 32'h0);
    check("unm_c000_err1",   32'({hreadyout, hresp}), 32'b01);
    collect();
    #1;
    check("idle_after_err", 32'({hreadyout, hresp}), 32'b10);
    addr_ph(32'h0001_0000, 1'b0);
    push_exp("unm_hi", 32'h0, 1'b1, 1);
    tick();
    bus_idle();
    collect();

    // Target-reported error from conf while not ready
    t_hready = 3'b110;
    t_hresp  = 3'b001;
    addr_ph(32'h0000_1000, 1'b0);
    push_exp("tgt_err", 32'h0, 1'b1, 2);
    tick();
    bus_idle();
    #1;
    check("tgt_err_t_haddr", 32'(t_haddr), 32'h1000);
    check("tgt_err_t_hsel",  32'(t_hsel),  32'h1);
    collect();
    t_hready = 3'b111;
    t_hresp  = 3'b000;
    #1;
    check("idle_after_tgt_err", 32'({hreadyout, hresp}), 32'b10);

    // dma stalls two cycles while the next access (to stalled mpsimple) waits;
    // the second access must see a fresh watchdog count
    t_hready = 3'b001;
    addr_ph(32'h0000_8000, 1'b0);
    push_exp("dma_stall", 32'h30, 1'b0, 0);
    tick();
    addr_ph(32'h0000_4004, 1'b0);
    push_exp("mps_timeout", 32'h0, 1'b1, 5);
    @(negedge clk);
    check("dma_stall_w1", 32'(hreadyout), 32'd0);
    tick();
    @(negedge clk);
    check("dma_stall_w2", 32'(hreadyout), 32'd0);
    tick();
    t_hready = 3'b101;
    collect();
    bus_idle();
    collect();
    t_hready = 3'b111;

    // A new accept during ERR2 is honoured
    addr_ph(32'h0000_C000, 1'b0);
    push_exp("unm_before_rd", 32'h0, 1'b1, 1);
    tick();
    addr_ph(32'h0000_0008, 1'b0);
    push_exp("rd_in_err2", 32'h10, 1'b0, 0);
    collect();
    bus_idle();
    #1;
    check("rd_in_err2_t_haddr", 32'(t_haddr), 32'h0008);
    collect();

    // BUSY with hsel high is a zero-wait OKAY and starts no target access
    hsel   = 1'b1;
    htrans = 2'b01;
    haddr  = 32'h0000_4000;
    tick();
    bus_idle();
    #1;
    check("busy_t_hsel", 32'(t_hsel), 32'h0);
    check("busy_resp",   32'({hreadyout, hresp}), 32'b10);

    // Reset while a data phase is waiting
    t_hready = 3'b110;
    addr_ph(32'h0000_0000, 1'b0);
    tick();
    bus_idle();
    @(negedge clk);
    check("rst_mid_wait", 32'(hreadyout), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    #1;
    check("rst_mid_t_hsel", 32'(t_hsel), 32'h0);
    check("rst_mid_resp",   32'({hreadyout, hresp}), 32'b10);
    check("rst_mid_hrdata", hrdata, 32'h0);
    rst = 1'b0;
    t_hready = 3'b111;
    tick();

    // Second DUT: absent dma target decodes as unmapped
    rst2 = 1'b0;
    tick();
    addr_ph(32'h0000_8000, 1'b0);
    tick();
    bus_idle();
    #1;
    check("dut2_unm_t_hsel", 32'(t_hsel2), 32'h0);
    @(negedge clk);
    check("dut2_unm_err1", 32'({hreadyout2, hresp2}), 32'b01);
    tick();
    @(negedge clk);
    check("dut2_unm_err2", 32'({hreadyout2, hresp2}), 32'b11);
    $display("xfer dut2_unm: err1/err2 observed");
    tick();

    // Second DUT: watchdog disabled, stall persists
    t_hready = 3'b101;
    addr_ph(32'h0000_4000, 1'b0);
    tick();
    bus_idle();
    low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!hreadyout2 && !hresp2) low++;
      tick();
    end
    check("dut2_stall_cycles", 32'(low), 32'd40);
    check("dut2_stall_t_hsel", 32'(t_hsel2), 32'h2);
    t_hready = 3'b111;
    @(negedge clk);
    check("dut2_release_ready", 32'({hreadyout2, hresp2}), 32'b10);
    check("dut2_release_rdata", hrdata2, 32'h20);
    $display("xfer dut2_stall: %0d wait cycles, hrdata=%h", low, hrdata2);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
